// File: rtl/dca_mru_step_ctrl.sv
// ============================================================================
// Module      : dca_mru_step_ctrl
// Description : MRU step controller. Gates blocked step instructions on LSU,
//               fill-value and write-credit availability, and drives a
//               registered, reshaped matrix write stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dca_mru_step_ctrl #(
    parameter int MATRIX_DIM   = 8,
    parameter int BW_SCALAR    = 32,
    parameter int CREDIT_DEPTH = 3
) (
    input  logic                                         clk,
    input  logic                                         rstnn,
    input  logic                                         clear,
    output logic                                         busy,
    input  logic                                         inst_valid,
    input  logic [3:0]                                   inst_code,
    output logic                                         inst_ready,
    input  logic                                         lsu_req_ready,
    output logic                                         lsu_req_valid,
    input  logic                                         fill_valid,
    input  logic [BW_SCALAR-1:0]                         fill_value,
    output logic                                         fill_pop,
    input  logic [MATRIX_DIM*MATRIX_DIM*BW_SCALAR-1:0]   in_matrix,
    output logic [MATRIX_DIM*MATRIX_DIM*BW_SCALAR-1:0]   out_matrix,
    output logic [MATRIX_DIM*MATRIX_DIM-1:0]             out_wenable,
    input  logic                                         out_accept,
    output logic                                         done,
    output logic                                         err_underflow
);

    localparam int BW_CREDIT = $clog2(CREDIT_DEPTH + 1);
    localparam int c_N       = MATRIX_DIM * MATRIX_DIM;

    localparam logic [BW_CREDIT-1:0] c_CREDIT_MAX  = BW_CREDIT'(CREDIT_DEPTH);
    localparam logic [BW_CREDIT-1:0] c_CREDIT_ZERO = '0;
    localparam logic [BW_CREDIT-1:0] c_CREDIT_ONE  = BW_CREDIT'(1);

    localparam logic [1:0] c_MODE_PASS      = 2'd0;
    localparam logic [1:0] c_MODE_TRANSPOSE = 2'd1;
    localparam logic [1:0] c_MODE_FILL      = 2'd2;

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]                 r_state;
    logic [0:0]                 w_state_nxt;
    logic [BW_CREDIT-1:0]       r_credit_cnt;
    logic [BW_CREDIT-1:0]       w_credit_nxt;
    logic                       r_err_underflow;
    logic                       w_underflow;
    logic [c_N*BW_SCALAR-1:0]   r_out_matrix;
    logic [c_N-1:0]             r_out_wenable;
    logic [c_N*BW_SCALAR-1:0]   w_shaped;

    logic                       w_active;
    logic                       w_last;
    logic                       w_lsu_req;
    logic [1:0]                 w_mode;
    logic                       w_need_fill;
    logic                       w_issue;
    logic                       w_done;

    assign w_active    = rstnn & ~clear;
    assign w_last      = inst_code[3];
    assign w_lsu_req   = inst_code[2];
    assign w_mode      = inst_code[1:0];
    assign w_need_fill = w_mode[1];

    // Reset/clear suppresses every handshake in the same cycle it is applied.
    assign w_issue = w_active
                   & (r_state == S_RUN)
                   & inst_valid
                   & (~w_lsu_req | lsu_req_ready)
                   & (~w_need_fill | fill_valid)
                   & (r_credit_cnt < c_CREDIT_MAX);

    assign inst_ready    = w_issue;
    assign lsu_req_valid = w_issue & w_lsu_req;
    assign fill_pop      = w_issue & w_last & w_need_fill;
    assign done          = w_done;
    assign busy          = inst_valid | (r_state == S_DRAIN);
    assign out_matrix    = r_out_matrix;
    assign out_wenable   = r_out_wenable;
    assign err_underflow = r_err_underflow;

    genvar gr, gc;
    generate
        for (gr = 0; gr < MATRIX_DIM; gr++) begin : g_row
            for (gc = 0; gc < MATRIX_DIM; gc++) begin : g_col
                logic [BW_SCALAR-1:0] w_diag;
                assign w_diag = (gr == gc) ? fill_value : '0;
                assign w_shaped[(gr*MATRIX_DIM+gc)*BW_SCALAR +: BW_SCALAR] =
                    (w_mode == c_MODE_PASS)      ? in_matrix[(gr*MATRIX_DIM+gc)*BW_SCALAR +: BW_SCALAR] :
                    (w_mode == c_MODE_TRANSPOSE) ? in_matrix[(gc*MATRIX_DIM+gr)*BW_SCALAR +: BW_SCALAR] :
                    (w_mode == c_MODE_FILL)      ? fill_value : w_diag;
            end
        end
    endgenerate

    // Simultaneous issue and accept cancel; an unmatched accept at zero flags underflow.
    always_comb begin
        w_credit_nxt = r_credit_cnt;
        w_underflow  = 1'b0;
        if (w_issue && !out_accept) begin
            w_credit_nxt = r_credit_cnt + c_CREDIT_ONE;
        end else if (!w_issue && out_accept) begin
            if (r_credit_cnt != c_CREDIT_ZERO) begin
                w_credit_nxt = r_credit_cnt - c_CREDIT_ONE;
            end else begin
                w_underflow = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        if (r_state == S_RUN) begin
            if (w_issue && w_last) begin
                w_state_nxt = S_DRAIN;
            end
        end else begin
            // Completion may coincide with the final accept of the sequence.
            if (w_active &&
                ((r_credit_cnt == c_CREDIT_ZERO) ||
                 ((r_credit_cnt == c_CREDIT_ONE) && out_accept))) begin
                w_state_nxt = S_RUN;
                w_done      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstnn || clear) begin
            r_state         <= S_RUN;
            r_credit_cnt    <= '0;
            r_err_underflow <= 1'b0;
            r_out_matrix    <= '0;
            r_out_wenable   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit_cnt  <= w_credit_nxt;
            r_out_wenable <= {c_N{w_issue}};
            if (w_underflow) begin
                r_err_underflow <= 1'b1;
            end
            if (w_issue) begin
                r_out_matrix <= w_shaped;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dca_mru_step_ctrl.sv
// ============================================================================
// Module      : tb_dca_mru_step_ctrl
// Description : Directed and randomized bench for dca_mru_step_ctrl, compared
//               cycle by cycle against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dca_mru_step_ctrl;

    localparam int D   = 8;
    localparam int BW  = 32;
    localparam int DEP = 3;
    localparam int N   = D * D;

    logic              clk = 1'b0;
    logic              rstnn, clear, inst_valid, lsu_req_ready, fill_valid, out_accept;
    logic [3:0]        inst_code;
    logic [BW-1:0]     fill_value;
    logic [N*BW-1:0]   in_matrix;
    logic              busy, inst_ready, lsu_req_valid, fill_pop, done, err_underflow;
    logic [N*BW-1:0]   out_matrix;
    logic [N-1:0]      out_wenable;

    always #5 clk = ~clk;

    dca_mru_step_ctrl #(.MATRIX_DIM(D), .BW_SCALAR(BW), .CREDIT_DEPTH(DEP)) dut (
        .clk(clk), .rstnn(rstnn), .clear(clear), .busy(busy),
        .inst_valid(inst_valid), .inst_code(inst_code), .inst_ready(inst_ready),
        .lsu_req_ready(lsu_req_ready), .lsu_req_valid(lsu_req_valid),
        .fill_valid(fill_valid), .fill_value(fill_value), .fill_pop(fill_pop),
        .in_matrix(in_matrix), .out_matrix(out_matrix), .out_wenable(out_wenable),
        .out_accept(out_accept), .done(done), .err_underflow(err_underflow)
    );

    int n_pass = 0, n_fail = 0, n_total = 0;
    int ready_pulses = 0, done_pulses = 0, lsu_pulses = 0, pop_pulses = 0;

    // Reference model: outstanding writes, sequence-in-progress flag, expected outputs.
    int              m_cnt   = 0;
    bit              m_drain = 1'b0;
    bit              m_err   = 1'b0;
    bit              m_we    = 1'b0;
    logic [N*BW-1:0] m_mat   = '0;
    bit              exp_issue, exp_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] elem(input logic [N*BW-1:0] m, input int r, input int c);
        return m[(r*D+c)*BW +: BW];
    endfunction

    function automatic logic [N*BW-1:0] shape(input logic [1:0] mode, input logic [N*BW-1:0] src,
                                              input logic [BW-1:0] fv);
        logic [N*BW-1:0] res;
        res = '0;
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++)
                case (mode)
                    2'd0:    res[(r*D+c)*BW +: BW] = elem(src, r, c);
                    2'd1:    res[(r*D+c)*BW +: BW] = elem(src, c, r);
                    2'd2:    res[(r*D+c)*BW +: BW] = fv;
                    default: res[(r*D+c)*BW +: BW] = (r == c) ? fv : '0;
                endcase
        return res;
    endfunction

    task automatic set_inst(input bit v, input bit last, input bit lsu, input logic [1:0] mode);
        inst_valid = v;
        inst_code  = {last, lsu, mode};
    endtask

    task automatic rand_matrix();
        for (int i = 0; i < N; i++) in_matrix[i*BW +: BW] = $urandom;
    endtask

    // One clock: predict, check combinational outputs mid-cycle, advance model, check registers.
    task automatic step(input string tag);
        bit act, last, lsu, nf;
        int bad;
        act  = rstnn && !clear;
        last = inst_code[3];
        lsu  = inst_code[2];
        nf   = (inst_code[1:0] == 2'd2) || (inst_code[1:0] == 2'd3);
        exp_issue = act && !m_drain && inst_valid && (!lsu || lsu_req_ready) &&
                    (!nf || fill_valid) && (m_cnt < DEP);
        exp_done  = act && m_drain && (m_cnt == 0 || (m_cnt == 1 && out_accept));
        @(negedge clk);
        check({tag, ":inst_ready"},    inst_ready,    exp_issue);
        check({tag, ":lsu_req_valid"}, lsu_req_valid, exp_issue && lsu);
        check({tag, ":fill_pop"},      fill_pop,      exp_issue && last && nf);
        check({tag, ":done"},          done,          exp_done);
        check({tag, ":busy"},          busy,          inst_valid || m_drain);
        if (inst_ready === 1'b1)    ready_pulses++;
        if (done === 1'b1)          done_pulses++;
        if (lsu_req_valid === 1'b1) lsu_pulses++;
        if (fill_pop === 1'b1)      pop_pulses++;
        if (!act) begin
            m_cnt = 0; m_drain = 0; m_err = 0; m_we = 0; m_mat = '0;
        end else begin
            if (exp_issue && !out_accept) m_cnt++;
            else if (!exp_issue && out_accept) begin
                if (m_cnt > 0) m_cnt--;
                else m_err = 1'b1;
            end
            if (exp_issue) begin
                m_mat = shape(inst_code[1:0], in_matrix, fill_value);
                if (last) m_drain = 1'b1;
            end
            if (exp_done) m_drain = 1'b0;
            m_we = exp_issue;
        end
        @(posedge clk);
        #1;
        check({tag, ":out_wenable"},   out_wenable,   {N{m_we}});
        check({tag, ":err_underflow"}, err_underflow, m_err);
        bad = -1;
        for (int i = N - 1; i >= 0; i--)
            if (out_matrix[i*BW +: BW] !== m_mat[i*BW +: BW]) bad = i;
        n_total++;
        assert (out_matrix === m_mat) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s:out_matrix elem %0d observed=%0h expected=%0h", tag, bad,
                   out_matrix[bad*BW +: BW], m_mat[bad*BW +: BW]);
        end
    endtask

    initial begin
        int k;
        rstnn = 0; clear = 0; inst_valid = 0; inst_code = '0; lsu_req_ready = 0;
        fill_valid = 0; fill_value = '0; out_accept = 0; in_matrix = '0;
        repeat (2) @(posedge clk);
        #1;
        step("reset");
        rstnn = 1;

        // Credit limit with no accepts, then a five-step PASS sequence drains.
        ready_pulses = 0; k = 0;
        for (int i = 0; i < 6; i++) begin
            rand_matrix(); set_inst(1, k == 4, 0, 2'd0); step("t1_fill");
            if (exp_issue) k++;
        end
        check("t1_issued_at_limit", ready_pulses, 3);
        for (int i = 0; i < 4; i++) begin
            out_accept = (i % 2 == 0);
            rand_matrix(); set_inst(1, k == 4, 0, 2'd0); step("t1_refill");
            if (exp_issue) k++;
        end
        check("t1_issued_total", ready_pulses, 5);
        out_accept = 0; set_inst(0, 0, 0, 2'd0); step("t1_drain_idle");
        check("t1_busy_in_drain", busy, 1);
        done_pulses = 0;
        out_accept = 1;
        repeat (3) step("t1_drain");
        out_accept = 0; step("t1_after");
        check("t1_done_pulses", done_pulses, 1);

        // TRANSPOSE with in(r,c) = r*16+c.
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++) in_matrix[(r*D+c)*BW +: BW] = BW'(r*16 + c);
        set_inst(1, 1, 0, 2'd1); step("t2_issue");
        check("t2_out_2_5", elem(out_matrix, 2, 5), 64'h52);
        check("t2_out_5_2", elem(out_matrix, 5, 2), 64'h25);
        check("t2_wenable", out_wenable, 64'hFFFF_FFFF_FFFF_FFFF);
        set_inst(0, 0, 0, 2'd0); out_accept = 1; step("t2_drain"); out_accept = 0;

        // DIAG waits for the fill scalar.
        ready_pulses = 0; pop_pulses = 0;
        rand_matrix(); set_inst(1, 1, 0, 2'd3); fill_value = 32'd7;
        repeat (4) step("t3_wait");
        check("t3_no_issue", ready_pulses, 0);
        fill_valid = 1; step("t3_issue"); fill_valid = 0;
        check("t3_issue_once", ready_pulses, 1);
        check("t3_pop_once", pop_pulses, 1);
        check("t3_diag_3_3", elem(out_matrix, 3, 3), 64'd7);
        check("t3_off_3_4", elem(out_matrix, 3, 4), 64'd0);
        set_inst(0, 0, 0, 2'd0); out_accept = 1; step("t3_drain"); out_accept = 0;

        // LSU backpressure.
        lsu_pulses = 0; ready_pulses = 0;
        rand_matrix(); set_inst(1, 0, 1, 2'd0);
        repeat (3) step("t4_blocked");
        lsu_req_ready = 1; step("t4_issue");
        set_inst(0, 0, 1, 2'd0); step("t4_idle");
        check("t4_lsu_pulses", lsu_pulses, 1);
        check("t4_ready_pulses", ready_pulses, 1);

        // Issue with accept at count 2, then underflow.
        set_inst(1, 0, 0, 2'd1); rand_matrix(); step("t5_to2");
        out_accept = 1; rand_matrix(); step("t5_issue_accept");
        set_inst(0, 0, 0, 2'd0);
        repeat (2) step("t5_drain");
        step("t5_underflow");
        out_accept = 0;
        repeat (2) step("t5_sticky");
        check("t5_err_sticky", err_underflow, 1);

        // Reset in DRAIN with two outstanding writes.
        set_inst(1, 0, 0, 2'd0); rand_matrix(); step("t6_a");
        set_inst(1, 1, 0, 2'd0); rand_matrix(); step("t6_b");
        set_inst(0, 0, 0, 2'd0); done_pulses = 0;
        rstnn = 0; step("t6_reset"); rstnn = 1;
        step("t6_idle");
        check("t6_no_done", done_pulses, 0);
        check("t6_err_cleared", err_underflow, 0);
        set_inst(1, 1, 0, 2'd2); fill_valid = 1; fill_value = $urandom; step("t6_new");
        fill_valid = 0; set_inst(0, 0, 0, 2'd0); out_accept = 1; step("t6_done");
        out_accept = 0;
        check("t6_done_pulses", done_pulses, 1);

        // Soft clear mid-sequence.
        set_inst(1, 1, 0, 2'd0); rand_matrix(); step("t7_issue");
        set_inst(0, 0, 0, 2'd0); clear = 1; step("t7_clear"); clear = 0;
        step("t7_idle");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            set_inst($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
            lsu_req_ready = $urandom_range(0, 3) != 0;
            fill_valid    = $urandom_range(0, 2) != 0;
            fill_value    = $urandom;
            out_accept    = $urandom_range(0, 2) == 0;
            clear         = $urandom_range(0, 59) == 0;
            rand_matrix();
            step("rand");
        end
        clear = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
